key_onehot_capture: RTL and testbench



---
 rtl/key_pkg.sv | 32 +++
 rtl/key_onehot_capture_if.sv | 34 +++
 rtl/vec_debounce.sv | 77 +++++++
 rtl/key_onehot_capture.sv | 94 +++++++++
 tb/tb_key_onehot_capture.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/key_pkg.sv
// -----------------------------------------------------------------------------
// key_pkg
// Shared types and constants for the key_onehot_capture block.
//   state_e                  : capture FSM states (IDLE / HELD)
//   KEY_W                    : number of push-button lines
//   DEBOUNCE_CYCLES_DEFAULT  : stable cycles before a vector is accepted
//                              (10 ms at 100 MHz)
//   CNT_W_DEFAULT            : debounce counter width
//   is_onehot()              : true when exactly one bit of a key vector is set
// -----------------------------------------------------------------------------
package key_pkg;

   localparam int unsigned KEY_W                   = 8;
   localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1_000_000;
   localparam int unsigned CNT_W_DEFAULT           = 20;

   typedef enum logic {
      IDLE = 1'b0,   // no key down, waiting for a debounced press
      HELD = 1'b1    // some combination down, waiting for full release
   } state_e;

   // Population count equal to one.
   function automatic logic is_onehot(input logic [KEY_W-1:0] v);
      int unsigned ones;
      ones = 0;
      for (int i = 0; i < KEY_W; i++) begin
         ones += 32'(v[i]);
      end
      return (ones == 1);
   endfunction

endpackage

// File: rtl/key_onehot_capture_if.sv
// -----------------------------------------------------------------------------
// key_onehot_capture_if
// Groups the key input and the captured-code outputs of key_onehot_capture.
//   iKey   : raw button lines, 1 = pressed, asynchronous to clk
//   oData  : captured one-hot key code, held until the next valid capture
//   oValid : one-cycle pulse when oData is loaded
//   oErr   : level, set by a multi-key press, cleared by the next capture
// Modports:
//   master : the side driving the buttons and consuming the code
//   slave  : the capture block itself
// -----------------------------------------------------------------------------
interface key_onehot_capture_if;
   import key_pkg::*;

   logic [KEY_W-1:0] iKey;
   logic [KEY_W-1:0] oData;
   logic             oValid;
   logic             oErr;

   modport master (
      output iKey,
      input  oData,
      input  oValid,
      input  oErr
   );

   modport slave (
      input  iKey,
      output oData,
      output oValid,
      output oErr
   );

endinterface

// File: rtl/vec_debounce.sv
// -----------------------------------------------------------------------------
// vec_debounce
// Two-flop synchroniser followed by a whole-vector debouncer. The vector is
// accepted into dout only after the synchronised value has been unchanged for
// DEBOUNCE_CYCLES consecutive clocks; any bit toggling restarts the window for
// every bit, so a glitch shorter than the window never reaches dout.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous, active-high reset
//   din  : raw asynchronous input vector
//   dout : debounced vector
// Parameters:
//   WIDTH           : vector width
//   DEBOUNCE_CYCLES : window length in clocks, minimum 2
//   CNT_W           : counter width, 2**CNT_W > DEBOUNCE_CYCLES
// -----------------------------------------------------------------------------
module vec_debounce #(
   parameter int unsigned WIDTH           = 8,
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned CNT_W           = 20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] meta_q,      meta_d;
   logic [WIDTH-1:0] sync_q,      sync_d;
   logic [WIDTH-1:0] sync_prev_q, sync_prev_d;
   logic [CNT_W-1:0] cnt_q,       cnt_d;
   logic [WIDTH-1:0] db_q,        db_d;

   always_comb begin
      // NOTE: every signal assigned here gets a default first; a path that
      // leaves one unassigned would infer a latch.
      meta_d      = din;
      sync_d      = meta_q;       // second synchroniser stage, no logic between
      sync_prev_d = sync_q;
      cnt_d       = cnt_q;
      db_d        = db_q;

      if (sync_q != sync_prev_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         // Window complete: keep loading the stable value, counter saturates.
         db_d = sync_q;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // NOTE: the synchroniser flops are reset too, so a key held through reset
   // is seen as a fresh 0 -> pressed transition and debounced from scratch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q      <= '0;
         sync_q      <= '0;
         sync_prev_q <= '0;
         cnt_q       <= '0;
         db_q        <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the values
         // from before this edge, independent of statement order.
         meta_q      <= meta_d;
         sync_q      <= sync_d;
         sync_prev_q <= sync_prev_d;
         cnt_q       <= cnt_d;
         db_q        <= db_d;
      end
   end

   assign dout = db_q;

endmodule

// File: rtl/key_onehot_capture.sv
// -----------------------------------------------------------------------------
// key_onehot_capture
// Upstream stage of the 8-to-3 encoder. Debounces eight push-button lines as
// one vector and captures a single-key press as a registered one-hot byte.
// A press of two or more keys is rejected and flagged on oErr. Once a
// combination is down, nothing further is captured until every key has been
// released, so adding or swapping keys mid-press is ignored.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous, active-high reset
//   bus : key_onehot_capture_if.slave (iKey in; oData, oValid, oErr out)
// Parameters:
//   DEBOUNCE_CYCLES : stable clocks required before a vector is accepted
//   CNT_W           : debounce counter width, 2**CNT_W > DEBOUNCE_CYCLES
// Latency: oValid rises DEBOUNCE_CYCLES+3 edges after the first edge that
// samples a stable iKey (2 synchroniser + 1 change detect + window + FSM).
// -----------------------------------------------------------------------------
module key_onehot_capture
   import key_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter int unsigned CNT_W           = CNT_W_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst,
   key_onehot_capture_if.slave  bus
);

   logic [KEY_W-1:0] db;

   state_e           state_q, state_d;
   logic [KEY_W-1:0] data_q,  data_d;
   logic             valid_q, valid_d;
   logic             err_q,   err_d;

   vec_debounce #(
      .WIDTH           (KEY_W),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_debounce (
      .clk  (clk),
      .rst  (rst),
      .din  (bus.iKey),
      .dout (db)
   );

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      valid_d = 1'b0;               // pulse: drops the edge after a capture
      err_d   = err_q;

      case (state_q)
         IDLE: begin
            if (db != '0) begin
               state_d = HELD;
               if (is_onehot(db)) begin
                  data_d  = db;
                  valid_d = 1'b1;
                  err_d   = 1'b0;
               end else begin
                  // Multi-key press: keep the previous code, only flag it.
                  err_d = 1'b1;
               end
            end
         end
         HELD: begin
            // Only a full release re-arms the capture.
            if (db == '0) begin
               state_d = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         data_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   assign bus.oData  = data_q;
   assign bus.oValid = valid_q;
   assign bus.oErr   = err_q;

endmodule

// File: tb/tb_key_onehot_capture.sv
// -----------------------------------------------------------------------------
// tb_key_onehot_capture
// Self-checking bench for key_onehot_capture with DEBOUNCE_CYCLES=4, CNT_W=3.
// The reference model works on the history of sampled key values: a value is
// accepted once it has been seen on D+1 consecutive samples, two edges of
// synchroniser delay earlier; a press is then classified one edge later.
// -----------------------------------------------------------------------------
module tb_key_onehot_capture;

   localparam int D = 4;

   logic clk = 1'b0;
   logic rst;

   int n_checks = 0;
   int n_errors = 0;

   key_onehot_capture_if bus ();

   key_onehot_capture #(
      .DEBOUNCE_CYCLES (D),
      .CNT_W           (3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference model state
   logic [7:0] hist[$];      // key samples since reset, most recent last
   logic [7:0] m_db;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_err;
   bit         m_held;
   int         pulses;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      hist.delete();
      m_db    = 8'h00;
      m_data  = 8'h00;
      m_valid = 1'b0;
      m_err   = 1'b0;
      m_held  = 1'b0;
   endtask

   // Samples from before reset read as 0 (the synchroniser restarts at 0).
   function automatic logic [7:0] hist_at(input int i);
      return (i < 0) ? 8'h00 : hist[i];
   endfunction

   task automatic model_edge(input logic [7:0] s);
      int         n;
      logic [7:0] v;
      bit         same;
      // Press classification uses the accepted vector from before this edge.
      m_valid = 1'b0;
      if (!m_held && m_db != 8'h00) begin
         m_held = 1'b1;
         if ($countones(m_db) == 1) begin
            m_data  = m_db;
            m_valid = 1'b1;
            m_err   = 1'b0;
         end else begin
            m_err = 1'b1;
         end
      end else if (m_held && m_db == 8'h00) begin
         m_held = 1'b0;
      end
      // Acceptance: the sample from two edges ago, stable over D+1 samples.
      hist.push_back(s);
      if (hist.size() > D + 3) void'(hist.pop_front());
      n    = hist.size();
      v    = hist_at(n - 3);
      same = 1'b1;
      for (int i = n - 3 - D; i < n - 3; i++) begin
         if (hist_at(i) != v) same = 1'b0;
      end
      if (same) m_db = v;
   endtask

   task automatic tick(input logic [7:0] k);
      bus.iKey = k;
      @(posedge clk);
      model_edge(k);
      #1;
      check("oData",  32'(bus.oData),  32'(m_data));
      check("oValid", 32'(bus.oValid), 32'(m_valid));
      check("oErr",   32'(bus.oErr),   32'(m_err));
      if (bus.oValid) pulses++;
   endtask

   task automatic hold(input logic [7:0] k, input int n);
      repeat (n) tick(k);
   endtask

   initial begin
      int         pulse_at;
      int         kind;
      int         a;
      int         b;
      logic [7:0] k;

      rst      = 1'b1;
      bus.iKey = 8'h00;
      model_reset();
      #1;
      check("rst_data",  32'(bus.oData),  32'h00);
      check("rst_valid", 32'(bus.oValid), 32'h0);
      check("rst_err",   32'(bus.oErr),   32'h0);
      @(negedge clk);
      rst = 1'b0;

      // 1: idle after reset
      pulses = 0;
      hold(8'h00, 20);
      check("t1_pulses", 32'(pulses),      32'd0);
      check("t1_data",   32'(bus.oData),   32'h00);
      check("t1_err",    32'(bus.oErr),    32'h0);

      // 2: single key, pulse exactly D+3 edges after first sample
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         tick(8'h08);
         if (i == D + 2) check("t2_early",   32'(bus.oValid), 32'h0);
         if (i == D + 3) check("t2_latency", 32'(bus.oValid), 32'h1);
      end
      check("t2_pulses", 32'(pulses),    32'd1);
      check("t2_data",   32'(bus.oData), 32'h08);
      hold(8'h00, 20);
      check("t2_data_release", 32'(bus.oData), 32'h08);

      // 3: short press is filtered, bouncing press captured once
      pulses = 0;
      hold(8'h04, 3);
      hold(8'h00, 15);
      check("t3_short_pulses", 32'(pulses),    32'd0);
      check("t3_short_data",   32'(bus.oData), 32'h08);
      pulse_at = -1;
      for (int j = 0; j < 30; j++) begin
         tick((j >= 10 || (j % 4) < 2) ? 8'h80 : 8'h00);
         if (bus.oValid) pulse_at = j;
      end
      // last bounce to 8'h80 sampled at j=8
      check("t3_bounce_at",     32'(pulse_at),  32'(8 + D + 3));
      check("t3_bounce_pulses", 32'(pulses),    32'd1);
      check("t3_bounce_data",   32'(bus.oData), 32'h80);
      hold(8'h00, 20);

      // 4: multi-key press rejected, next single press clears error
      pulses = 0;
      hold(8'h21, 20);
      check("t4_err",    32'(bus.oErr),  32'h1);
      check("t4_pulses", 32'(pulses),    32'd0);
      check("t4_data",   32'(bus.oData), 32'h80);
      hold(8'h00, 20);
      check("t4_err_released", 32'(bus.oErr), 32'h1);
      hold(8'h02, 20);
      check("t4_cap_pulses", 32'(pulses),    32'd1);
      check("t4_cap_data",   32'(bus.oData), 32'h02);
      check("t4_cap_err",    32'(bus.oErr),  32'h0);
      hold(8'h00, 20);

      // 5: keys added/swapped while held are ignored
      pulses = 0;
      hold(8'h01, 12);
      hold(8'h11, 12);
      hold(8'h10, 12);
      check("t5_pulses", 32'(pulses),    32'd1);
      check("t5_data",   32'(bus.oData), 32'h01);
      hold(8'h00, 15);
      hold(8'h10, 12);
      check("t5_new_pulses", 32'(pulses),    32'd2);
      check("t5_new_data",   32'(bus.oData), 32'h10);
      hold(8'h00, 20);

      // 6: reset in the middle of a held key
      hold(8'h40, 12);
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      #1;
      check("t6_rst_data",  32'(bus.oData),  32'h00);
      check("t6_rst_valid", 32'(bus.oValid), 32'h0);
      check("t6_rst_err",   32'(bus.oErr),   32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst    = 1'b0;
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         tick(8'h40);
         if (i == D + 3) check("t6_latency", 32'(bus.oValid), 32'h1);
      end
      check("t6_pulses", 32'(pulses),    32'd1);
      check("t6_data",   32'(bus.oData), 32'h40);
      hold(8'h00, 20);

      // Random mix of idle, single-key, multi-key and glitch segments
      repeat (80) begin
         kind = int'($urandom_range(0, 2));
         a    = int'($urandom_range(0, 7));
         b    = (a + 1 + int'($urandom_range(0, 6))) % 8;
         case (kind)
            0:       k = 8'h00;
            1:       k = 8'h01 << a;
            default: k = (8'h01 << a) | (8'h01 << b);
         endcase
         hold(k, int'($urandom_range(1, 14)));
      end
      hold(8'h00, 20);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
